// File: rtl/serdes_pkg.sv
// Constants and FSM encoding shared by the 10:1 serializer and its
// deserializer counterpart.
package serdes_pkg;

    localparam int   SERDES_WIDTH    = 10;
    localparam logic SERDES_IDLE_BIT = 1'b0;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

endpackage

// File: rtl/serializer_10to1.sv
// Parallel-to-serial transmitter: WIDTH-bit words in over valid/ready,
// MSB-first serial out with a frame strobe on each word's first bit.
module serializer_10to1
    import serdes_pkg::*;
#(
    parameter int   WIDTH    = SERDES_WIDTH,
    parameter logic IDLE_BIT = SERDES_IDLE_BIT
) (
    input  logic             clkGHz,
    input  logic             reset,
    input  logic             enable_n,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready,
    output logic             data_o,
    output logic             frame_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;

    tx_state_t        w_state_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic [WIDTH-1:0] w_shift_n;
    logic [WIDTH-1:0] w_hold_n;
    logic             w_hold_full_n;
    logic             w_data_n;
    logic             w_frame_n;
    logic             w_last;
    logic             w_load;
    logic             w_accept;

    assign ready    = !r_hold_full && !enable_n && !reset;
    assign w_accept = valid_i && ready;
    assign w_last   = (r_state == TX_SHIFT) && (r_cnt == LAST);
    // A buffered word starts from IDLE or right behind the last bit, so
    // streaming words leave no gap on the line.
    assign w_load   = r_hold_full && ((r_state == TX_IDLE) || w_last);

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_shift_n     = r_shift;
        w_hold_n      = r_hold;
        w_hold_full_n = r_hold_full;
        w_data_n      = data_o;
        w_frame_n     = frame_o;

        if (w_load) begin
            // The shifter keeps the not-yet-sent bits left-aligned.
            w_shift_n     = {r_hold[WIDTH-2:0], 1'b0};
            w_data_n      = r_hold[WIDTH-1];
            w_frame_n     = 1'b1;
            w_cnt_n       = '0;
            w_state_n     = TX_SHIFT;
            w_hold_full_n = 1'b0;
        end else if (r_state == TX_SHIFT) begin
            w_frame_n = 1'b0;
            if (w_last) begin
                w_data_n  = IDLE_BIT;
                w_state_n = TX_IDLE;
            end else begin
                w_data_n  = r_shift[WIDTH-1];
                w_shift_n = {r_shift[WIDTH-2:0], 1'b0};
                w_cnt_n   = r_cnt + 1'b1;
            end
        end

        if (w_accept) begin
            w_hold_n      = data_i;
            w_hold_full_n = 1'b1;
        end
    end

    always_ff @(posedge clkGHz) begin
        if (reset) begin
            r_state     <= TX_IDLE;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
            data_o      <= IDLE_BIT;
            frame_o     <= 1'b0;
        end else if (!enable_n) begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_shift     <= w_shift_n;
            r_hold      <= w_hold_n;
            r_hold_full <= w_hold_full_n;
            data_o      <= w_data_n;
            frame_o     <= w_frame_n;
        end
    end

endmodule

// File: tb/tb_serializer_10to1.sv
// Scoreboard bench for serializer_10to1: stimulus queues expected words,
// a monitor reassembles framed serial words and compares them.
module tb_serializer_10to1;
    import serdes_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_n = 1'b0;
    logic [9:0] data_i = '0;
    logic       valid_i = 1'b0;
    logic       ready, data_o, frame_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int words_seen = 0;
    int rdy_cnt = 0;
    bit win = 0;
    bit in_word = 0;
    logic [9:0] exp_q[$];
    int frame_log[$];
    int acc_log[$];

    serializer_10to1 dut (
        .clkGHz  (clk),
        .reset   (reset),
        .enable_n(enable_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready   (ready),
        .data_o  (data_o),
        .frame_o (frame_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: only edges that actually advance the DUT carry a new bit.
    always begin
        bit         act_edge, rst_edge;
        int         nbits;
        logic [9:0] sh;
        logic [9:0] e;
        @(posedge clk);
        cyc++;
        act_edge = !reset && !enable_n;
        rst_edge = reset;
        #1;
        if (rst_edge) begin
            in_word = 0;
            nbits   = 0;
        end else if (act_edge) begin
            if (frame_o) begin
                chk("frame_inside_word", in_word, 0);
                in_word = 1;
                nbits   = 1;
                sh      = {9'b0, data_o};
                frame_log.push_back(cyc);
            end else if (in_word) begin
                sh = {sh[8:0], data_o};
                nbits++;
            end else begin
                chk("idle_level", data_o, SERDES_IDLE_BIT);
            end
            if (in_word && nbits == 10) begin
                in_word = 0;
                words_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", sh, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", sh, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (win) begin
            #1;
            if (ready) rdy_cnt++;
        end
    end

    task automatic send(input logic [9:0] w);
        int n = 0;
        @(negedge clk);
        data_i  = w;
        valid_i = 1'b1;
        #1;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
            #1;
        end
        if (!ready) begin
            chk("ready_timeout", 0, 1);
        end else begin
            exp_q.push_back(w);
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            acc_log.push_back(cyc);
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || in_word) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, (exp_q.size() == 0 && !in_word), 1);
    endtask

    initial begin
        logic d_hold, f_hold;
        int   seen;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_o", data_o, SERDES_IDLE_BIT);
        chk("rst_frame_o", frame_o, 0);
        chk("rst_ready", ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", ready, 1);

        // Single word 10'h2B5 -> 1010110101, MSB one cycle after accept
        frame_log.delete();
        send(10'h2B5);
        drop_valid();
        drain("single_drain");
        chk("single_frame_count", frame_log.size(), 1);
        if (frame_log.size() == 1) chk("single_latency", frame_log[0] - acc_cyc, 1);

        // Back-to-back stream with valid held: accepts at +0,+2,+12, frames every 10
        repeat (3) @(negedge clk);
        frame_log.delete();
        acc_log.delete();
        rdy_cnt = 0;
        win = 1;
        send(10'h3FF);
        send(10'h000);
        send(10'h155);
        win = 0;
        drop_valid();
        drain("stream_drain");
        chk("stream_ready_cycles", rdy_cnt, 3);
        chk("stream_frames", frame_log.size(), 3);
        if (acc_log.size() == 3) begin
            chk("stream_acc_gap1", acc_log[1] - acc_log[0], 2);
            chk("stream_acc_gap2", acc_log[2] - acc_log[1], 10);
        end
        if (frame_log.size() == 3) begin
            chk("stream_first_bit", frame_log[0] - acc_log[0], 1);
            chk("stream_gap1", frame_log[1] - frame_log[0], 10);
            chk("stream_gap2", frame_log[2] - frame_log[1], 10);
        end

        // Enable pause after 5 bits of 10'h0F0 (0,0,1,1,1 shown; 1 on the line)
        repeat (2) @(negedge clk);
        send(10'h0F0);
        drop_valid();
        repeat (5) @(posedge clk);
        @(negedge clk);
        enable_n = 1'b1;
        d_hold = data_o;
        f_hold = frame_o;
        chk("pause_bit4", d_hold, 1);
        repeat (5) begin
            @(negedge clk);
            chk("pause_data_held", data_o, d_hold);
            chk("pause_frame_held", frame_o, f_hold);
            chk("pause_ready", ready, 0);
        end
        enable_n = 1'b0;
        drain("pause_drain");

        // Boundary words with an idle gap between them
        send(10'h001);
        drop_valid();
        drain("lsb_only_drain");
        send(10'h200);
        drop_valid();
        drain("msb_only_drain");

        // Reset at bit 6 of 10'h2AA with 10'h155 buffered: both discarded
        repeat (2) @(negedge clk);
        send(10'h2AA);
        send(10'h155);
        repeat (4) @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        seen = words_seen;
        @(posedge clk);
        #1;
        chk("midrst_data_o", data_o, 0);
        chk("midrst_frame_o", frame_o, 0);
        chk("midrst_ready", ready, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("midrst_no_words", words_seen, seen);
        chk("midrst_idle", in_word, 0);

        // Normal traffic resumes after the mid-word reset
        send(10'h1C3);
        drop_valid();
        drain("post_rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
